// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready stream and
// writes each one as four little-endian bytes, then pulses start to release the core.
module imem_loader #(
  parameter int unsigned BASE_ADDR = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              start,
  output logic              busy,
  output logic [15:0]       word_count,
  output logic              err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    START = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_q, byte_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    count_d;
  logic                room;
  logic                in_ready_d, mem_we_d, start_d, busy_d, err_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [BYTE_W-1:0]   mem_wdata_d;

  // Byte address of byte k of word n, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [CNT_W-1:0] n,
                                                  input logic [1:0] k);
    logic [31:0] sum;
    sum = 32'(BASE_ADDR) + {14'd0, n, 2'b00} + {30'd0, k};
    return ADDR_W'(sum);
  endfunction

  // Next-state and next-output decode; all outputs are registered from these values.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    word_d      = word_q;
    last_d      = last_q;
    count_d     = word_count;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    start_d     = 1'b0;
    room        = 32'(word_count) < MAX_WORDS;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          word_d      = in_data;
          last_d      = in_last;
          byte_d      = 2'd0;
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = byte_addr(word_count, 2'd0);
          mem_wdata_d = in_data[7:0];
        end else if (in_valid && !room) begin
          state_d = ERROR;
        end
      end
      WRITE: begin
        if (byte_q == 2'd3) begin
          count_d = word_count + 16'd1;
          state_d = last_q ? START : IDLE;
          start_d = last_q;
        end else begin
          byte_d      = byte_q + 2'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = byte_addr(word_count, byte_d);
          mem_wdata_d = word_q[BYTE_W*byte_d +: BYTE_W];
        end
      end
      START:   state_d = DONE;
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) && (32'(count_d) < MAX_WORDS);
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    err_d      = (state_d == ERROR);
  end

  // State, latched word and registered outputs; reset aborts any write in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_q     <= 2'd0;
      word_q     <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      word_q     <= word_d;
      last_q     <= last_d;
      word_count <= count_d;
      in_ready   <= in_ready_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      start      <= start_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: three instances (default, MAX_WORDS=2,
// BASE_ADDR=1020) each checked every cycle against a queue-based timeline model.
module tb_imem_loader;

  localparam int unsigned NI = 3;
  localparam int unsigned AW = 10;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          start;
    logic [15:0]   wc;
    logic          busy;
    logic          ready;
    logic          err;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset      [NI];
  logic          in_valid   [NI];
  logic          in_ready   [NI];
  logic [31:0]   in_data    [NI];
  logic          in_last    [NI];
  logic          mem_we     [NI];
  logic [AW-1:0] mem_addr   [NI];
  logic [7:0]    mem_wdata  [NI];
  logic          start      [NI];
  logic          busy       [NI];
  logic [15:0]   word_count [NI];
  logic          err        [NI];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem [NI][1024];
  int starts [NI];
  int start_cyc [NI];

  logic [31:0] prog [4] = '{32'h00a00293, 32'h06500313, 32'h0062a023, 32'h0002af83};
  logic [7:0]  img [16] = '{8'h93, 8'h02, 8'ha0, 8'h00, 8'h13, 8'h03, 8'h50, 8'h06,
                            8'h23, 8'ha0, 8'h62, 8'h00, 8'h83, 8'haf, 8'h02, 8'h00};

  // cycle counter used to time the start pulse against the accept cycle
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned B = (g == 2) ? 1020 : 4;
    localparam int unsigned M = (g == 1) ? 2 : 256;

    imem_loader #(.BASE_ADDR(B), .ADDR_W(AW), .MAX_WORDS(M)) u_dut (
      .clock(clock), .reset(reset[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]), .in_last(in_last[g]),
      .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .start(start[g]), .busy(busy[g]), .word_count(word_count[g]), .err(err[g])
    );

    obs_t cur;
    bit   cur_idle;
    obs_t q [$];
    int   cnt;
    bit   done_f, err_f;

    // timeline model: an accepted word schedules four write cycles (plus a start cycle if last)
    always @(posedge clock) begin : model
      obs_t r;
      if (reset[g]) begin
        q.delete(); cnt = 0; done_f = 0; err_f = 0;
      end else if (cur_idle && in_valid[g]) begin
        if (cnt < M) begin
          for (int k = 0; k < 4; k++) begin
            r = '0; r.we = 1'b1; r.busy = 1'b1; r.wc = 16'(cnt);
            r.addr = AW'((B + 4 * cnt + k) % 1024);
            r.data = in_data[g][8*k +: 8];
            q.push_back(r);
          end
          cnt++;
          if (in_last[g]) begin
            r = '0; r.start = 1'b1; r.busy = 1'b1; r.wc = 16'(cnt);
            q.push_back(r);
            done_f = 1;
          end
        end else begin
          err_f = 1;
        end
      end
      cur = '0; cur_idle = 0;
      if (q.size() > 0) cur = q.pop_front();
      else if (done_f) cur.wc = 16'(cnt);
      else if (err_f) begin cur.wc = 16'(cnt); cur.busy = 1'b1; cur.err = 1'b1; end
      else begin cur.wc = 16'(cnt); cur.ready = (cnt < M); cur_idle = 1; end
    end

    // compare DUT outputs with the model mid-cycle; also build the observed memory image
    always @(negedge clock) begin : cmp
      obs_t act;
      act.we = mem_we[g]; act.addr = mem_addr[g]; act.data = mem_wdata[g];
      act.start = start[g]; act.wc = word_count[g]; act.busy = busy[g];
      act.ready = in_ready[g]; act.err = err[g];
      checks++;
      if (reset[g]) begin
        if (act.we || act.start || act.busy || act.err || act.addr != '0 || act.data != '0 || act.wc != '0) begin
          errors++;
          $display("FAIL reset_out g%0d t=%0t actual=%h required=zero", g, $time, act);
        end
        for (int i = 0; i < 1024; i++) mem[g][i] = -1;
        starts[g] = 0; start_cyc[g] = -1;
      end else begin
        if (act !== cur) begin
          errors++;
          $display("FAIL cycle g%0d t=%0t actual=%h required=%h", g, $time, act, cur);
        end
        if (act.we) mem[g][act.addr] = int'(act.data);
        if (act.start) begin starts[g]++; start_cyc[g] = cyc; end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input int g);
    reset[g] = 1'b1;
    @(posedge clock); #2;
    reset[g] = 1'b0;
  endtask

  // offer one word until accepted; rnd toggles in_valid and scrambles in_data while idle-offered
  task automatic send(input int g, input logic [31:0] d, input logic last, input bit rnd, output int acc);
    bit hs;
    int n;
    hs = 0; n = 0; acc = -1;
    in_last[g] = last;
    while (!hs && n < 60) begin
      in_valid[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data[g]  = in_valid[g] ? d : $urandom;
      @(negedge clock);
      hs = in_valid[g] && in_ready[g];
      if (hs) acc = cyc;
      @(posedge clock); #2;
      n++;
    end
    in_valid[g] = 1'b0;
    in_data[g]  = $urandom;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL handshake_timeout g%0d actual=none required=accept", g);
    end
  endtask

  task automatic load_prog(input int g, input bit rnd);
    int acc;
    for (int i = 0; i < 4; i++) send(g, prog[i], i == 3, rnd, acc);
  endtask

  task automatic chk_img(input int g);
    for (int i = 0; i < 16; i++) chk("img_byte", mem[g][4 + i], int'(img[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic [31:0] w [8];
    for (int g = 0; g < NI; g++) begin
      reset[g] = 1'b1; in_valid[g] = 1'b0; in_data[g] = '0; in_last[g] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #2;
    for (int g = 0; g < NI; g++) reset[g] = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", int'(in_ready[0]), 1);
    chk("wc_after_reset", int'(word_count[0]), 0);
    @(posedge clock); #2;

    // program with in_valid held high, then in_valid ignored in DONE
    load_prog(0, 0);
    in_valid[0] = 1'b1;
    wait_cycles(10);
    in_valid[0] = 1'b0;
    chk_img(0);
    chk("wc_prog", int'(word_count[0]), 4);
    chk("starts_prog", starts[0], 1);

    // same program with random valid toggling
    do_reset(0);
    load_prog(0, 1);
    wait_cycles(8);
    chk_img(0);
    chk("wc_rand", int'(word_count[0]), 4);
    chk("starts_rand", starts[0], 1);

    // reset during the third byte of the first word, then full reload
    do_reset(0);
    send(0, prog[0], 1'b0, 0, acc);
    wait_cycles(2);
    reset[0] = 1'b1;
    @(posedge clock); #2;
    reset[0] = 1'b0;
    @(negedge clock);
    chk("wc_abort", int'(word_count[0]), 0);
    chk("start_abort", int'(start[0]), 0);
    chk("byte4_abort_cleared", mem[0][4], -1);
    @(posedge clock); #2;
    load_prog(0, 0);
    wait_cycles(8);
    chk_img(0);
    chk("wc_reload", int'(word_count[0]), 4);
    chk("starts_reload", starts[0], 1);

    // single-word program: start five cycles after accept, DONE ignores in_valid
    do_reset(0);
    send(0, 32'h00000013, 1'b1, 0, acc);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'hdeadbeef;
    wait_cycles(12);
    in_valid[0] = 1'b0;
    chk("start_latency", start_cyc[0] - acc, 5);
    chk("starts_single", starts[0], 1);
    chk("single_b4", mem[0][4], 'h13);
    chk("single_b5", mem[0][5], 0);
    chk("single_b7", mem[0][7], 0);
    chk("single_b8_unwritten", mem[0][8], -1);
    chk("wc_single", int'(word_count[0]), 1);

    // overflow with MAX_WORDS=2
    do_reset(1);
    send(1, prog[0], 1'b0, 0, acc);
    send(1, prog[1], 1'b0, 0, acc);
    in_data[1] = prog[2];
    in_valid[1] = 1'b1;
    wait_cycles(8);
    in_valid[1] = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 8; i++) chk("ovf_img", mem[1][4 + i], int'(img[i]));
    chk("ovf_addr12", mem[1][12], -1);
    chk("ovf_err", int'(err[1]), 1);
    chk("ovf_starts", starts[1], 0);
    chk("ovf_wc", int'(word_count[1]), 2);

    // address wrap with BASE_ADDR=1020
    do_reset(2);
    send(2, prog[0], 1'b0, 0, acc);
    send(2, prog[1], 1'b1, 0, acc);
    wait_cycles(8);
    for (int i = 0; i < 4; i++) chk("wrap_w0", mem[2][1020 + i], int'(img[i]));
    for (int i = 0; i < 4; i++) chk("wrap_w1", mem[2][i], int'(img[4 + i]));
    chk("wrap_starts", starts[2], 1);

    // random programs with random valid toggling
    for (int t = 0; t < 3; t++) begin
      do_reset(0);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) w[i] = $urandom;
      for (int i = 0; i < n; i++) send(0, w[i], i == n - 1, 1, acc);
      wait_cycles(8);
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++)
          chk("rand_img", mem[0][4 + 4 * i + k], int'((w[i] >> (8 * k)) & 32'hff));
      chk("rand_wc", int'(word_count[0]), n);
      chk("rand_starts", starts[0], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
